// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file slice: default sizes, the
// clear/ready state type and the default register address type.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // INIT walks the array clearing one entry per cycle; READY is normal operation.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: writeback port, packed read ports with hazard flags,
// scoreboard issue port and the init_done status.
//   master : pipeline side (drives writes, reads, issue)
//   slave  : register file side
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                init_done;

    modport master (
        output we, wa, wd, ra, issue_en, issue_rd,
        input  rd, rd_busy, init_done
    );

    modport slave (
        input  we, wa, wd, ra, issue_en, issue_rd,
        output rd, rd_busy, init_done
    );

endinterface

// File: rtl/regfile_sb_busy_scoreboard.sv
// Busy-bit scoreboard: one flag per register, set by issue, cleared by
// writeback, wiped by clear_all. Reports per-read-port hazards, masked when
// the same-cycle writeback targets the port's register.
//   clk, reset         : clock, synchronous active-high reset
//   clear_all          : clear every busy flag at the next edge
//   set_en, set_idx    : mark set_idx as having a pending producer
//   clr_en, clr_idx    : writeback to clr_idx clears its flag
//   ra                 : packed read addresses
//   hazard             : per-port busy flag after bypass masking
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_all,
    input  logic              set_en,
    input  logic [AW-1:0]     set_idx,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_idx,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    hazard
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic [AW-1:0]    ra_s [NRD];

    // Set mask: register 0 never becomes busy when it is hardwired to zero.
    always_comb begin
        set_mask_s = {NREGS{1'b0}};
        if (set_en && !(ZERO_REG && (set_idx == {AW{1'b0}}))) begin
            set_mask_s[set_idx] = 1'b1;
        end else begin
            set_mask_s = {NREGS{1'b0}};
        end
    end

    // Clear mask from the writeback port.
    always_comb begin
        clr_mask_s = {NREGS{1'b0}};
        if (clr_en) begin
            clr_mask_s[clr_idx] = 1'b1;
        end else begin
            clr_mask_s = {NREGS{1'b0}};
        end
    end

    // Busy flags; set is applied after clear so a new producer wins a tie.
    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Unpack read addresses.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra_s[i] = ra[i*AW +: AW];
        end
    end

    // Hazard lookup; a same-cycle writeback resolves the hazard via bypass.
    always_comb begin
        hazard = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            hazard[i] = busy_r[ra_s[i]] && !(clr_en && (clr_idx == ra_s[i]));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one synchronous
// write port with write-to-read bypass, a busy-bit scoreboard, and a
// post-reset sequencer that zeroes every entry before reporting init_done.
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high reset, restarts the clear sequence
//   bus    : regfile_sb_if slave (write, read, issue, init_done)
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    rf_state_e           state_r;
    rf_state_e           state_nxt_s;
    logic [AW-1:0]       cnt_r;
    logic [AW-1:0]       cnt_nxt_s;
    logic                init_done_r;
    logic [XLEN-1:0]     rf_r [NREGS];
    logic [AW-1:0]       ra_s [NRD];
    logic [NRD*XLEN-1:0] rd_s;
    logic [NRD-1:0]      hazard_s;
    logic                ready_s;
    logic                clear_s;
    logic                we_eff_s;
    logic                set_eff_s;

    assign ready_s   = (state_r == READY);
    assign clear_s   = !ready_s;
    assign we_eff_s  = ready_s && bus.we && ((bus.wa != {AW{1'b0}}) || !ZERO_REG);
    assign set_eff_s = ready_s && bus.issue_en;

    // FSM state, clear counter and init_done register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= INIT;
            cnt_r       <= {AW{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            init_done_r <= (state_nxt_s == READY);
        end
    end

    // FSM next state: INIT advances one entry per cycle until the last one.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            INIT: begin
                cnt_nxt_s = cnt_r + 1'b1;
                if (cnt_r == AW'(NREGS - 1)) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            READY: begin
                state_nxt_s = READY;
                cnt_nxt_s   = cnt_r;
            end
            default: begin
                state_nxt_s = INIT;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Data array: clear sequencer has priority; writes only in READY.
    always_ff @(posedge clk) begin
        if (state_r == INIT) begin
            rf_r[cnt_r] <= {XLEN{1'b0}};
        end else if (!reset && we_eff_s) begin
            rf_r[bus.wa] <= bus.wd;
        end
    end

    // Unpack read addresses.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra_s[i] = bus.ra[i*AW +: AW];
        end
    end

    // Read muxes: zero register, then same-cycle bypass, then array.
    always_comb begin
        rd_s = {(NRD*XLEN){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (!ready_s) begin
                rd_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (ZERO_REG && (ra_s[i] == {AW{1'b0}})) begin
                rd_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (we_eff_s && (bus.wa == ra_s[i])) begin
                rd_s[i*XLEN +: XLEN] = bus.wd;
            end else begin
                rd_s[i*XLEN +: XLEN] = rf_r[ra_s[i]];
            end
        end
    end

    busy_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_busy_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_s),
        .set_en    (set_eff_s),
        .set_idx   (bus.issue_rd),
        .clr_en    (we_eff_s),
        .clr_idx   (bus.wa),
        .ra        (bus.ra),
        .hazard    (hazard_s)
    );

    assign bus.rd        = rd_s;
    assign bus.rd_busy   = hazard_s & {NRD{ready_s}};
    assign bus.init_done = init_done_r;

endmodule
